// File: rtl/idex_hazard_ctrl.sv
// ============================================================================
// IdexHazardCtrl -- decode-side hazard controller (module idex_hazard_ctrl)
// ============================================================================
// Decides every cycle what the ID/EX pipeline register captures: either the
// decoded instruction or a bubble. It also decides whether the front end
// (PC and IF/ID) advances, holds, or is squashed to a NOP.
//
// A shadow scoreboard follows the destination register of each instruction
// through EX and MEM. It is used to detect load-use hazards. EX-stage
// redirects (taken branch, jal, jalr) squash the wrong-path instructions for
// FLUSH_CYCLES cycles.
//
// Parameters
//   RA_W          register-address width of the rs1/rs2/rd fields
//   FLUSH_CYCLES  squash cycles applied per redirect (1..7)
//   CNT_W         width of the saturating performance counters
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   id_instr     in   instruction in ID (opcode [6:0], rd [11:7],
//                     rs1 [19:15], rs2 [24:20])
//   id_regwrite  in   decoded regwrite of the ID instruction
//   id_memread   in   decoded memread (load) of the ID instruction
//   ex_redirect  in   EX resolved a taken branch/jal/jalr this cycle
//   pc_write     out  1 = PC may advance
//   ifid_write   out  1 = IF/ID register may load
//   ifid_flush   out  1 = IF/ID loads a NOP
//   idex_bubble  out  1 = ID/EX loads all-zero control fields
//   hz_state     out  current FSM state (RUN=0, LDSTALL=1, FLUSH=2)
//   stall_cnt    out  load-use stall cycles, saturating
//   flush_cnt    out  redirect squash cycles, saturating
// ============================================================================
module idex_hazard_ctrl #(
    parameter int RA_W         = 5,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      id_instr,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             ex_redirect,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // The state encoding is visible on hz_state, so the values are fixed.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        LDSTALL = 2'd1,
        FLUSH   = 2'd2
    } hzState_e;

    // Three bits hold any remaining-squash count up to 7 cycles.
    localparam int SQ_W = 3;

    // The redirect cycle itself is the first squash cycle. The FLUSH state
    // therefore only covers the remaining FLUSH_CYCLES-1 cycles.
    localparam logic [SQ_W-1:0] SQUASH_RELOAD = SQ_W'(FLUSH_CYCLES - 1);

    // RISC-V base opcodes that matter for source-register usage.
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    hzState_e         state_q, state_d;
    logic [SQ_W-1:0]  squashCnt_q, squashCnt_d;

    logic [RA_W-1:0]  exRd_q, memRd_q;
    logic             exWr_q, memWr_q;
    logic             exLd_q, memLd_q;

    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic [CNT_W-1:0] flushCnt_q, flushCnt_d;

    logic [6:0]       opcode;
    logic [RA_W-1:0]  idRd, idRs1, idRs2;
    logic             useRs1, useRs2;
    logic             loadUse;

    logic             pcWrite, ifidWrite, ifidFlush, idexBubble;
    logic             stallEvt, squashEvt;

    // The MEM copy of the scoreboard is shadow state only: a hit there is
    // covered by forwarding. The instruction bits outside the
    // opcode/register fields are not needed either. Folding them into one
    // explicitly unused net documents that this is intentional.
    logic             unusedBits;

    assign opcode = id_instr[6:0];
    assign idRd   = id_instr[7  +: RA_W];
    assign idRs1  = id_instr[15 +: RA_W];
    assign idRs2  = id_instr[20 +: RA_W];

    assign unusedBits = ^{id_instr, memRd_q, memWr_q, memLd_q};

    // Which source fields the ID instruction really reads. U-type, jal and
    // unknown opcodes read nothing. A stale field match on such an
    // instruction must never cause a stall.
    always_comb begin
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        case (opcode)
            OP_REG, OP_STORE, OP_BRANCH: begin
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            OP_IMM, OP_LOAD, OP_JALR: begin
                useRs1 = 1'b1;
            end
            default: begin
                useRs1 = 1'b0;
                useRs2 = 1'b0;
            end
        endcase
    end

    // A load still in EX cannot forward its data to the instruction now in
    // ID. x0 is never a real dependency.
    assign loadUse = exLd_q && exWr_q && (exRd_q != '0) &&
                     (((exRd_q == idRs1) && useRs1) ||
                      ((exRd_q == idRs2) && useRs2));

    // Next-state and control decisions. A redirect wins over everything,
    // because the ID instruction is on the wrong path. An ongoing squash
    // wins over a load-use for the same reason. LDSTALL behaves like RUN:
    // the load has moved on to MEM. A back-to-back load can still stall
    // again.
    always_comb begin
        state_d     = state_q;
        squashCnt_d = squashCnt_q;
        pcWrite     = 1'b1;
        ifidWrite   = 1'b1;
        ifidFlush   = 1'b0;
        idexBubble  = 1'b0;
        stallEvt    = 1'b0;
        squashEvt   = 1'b0;

        if (ex_redirect) begin
            ifidFlush  = 1'b1;
            idexBubble = 1'b1;
            squashEvt  = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_d     = FLUSH;
                squashCnt_d = SQUASH_RELOAD;
            end else begin
                state_d     = RUN;
                squashCnt_d = '0;
            end
        end else begin
            case (state_q)
                FLUSH: begin
                    ifidFlush   = 1'b1;
                    idexBubble  = 1'b1;
                    squashEvt   = 1'b1;
                    squashCnt_d = squashCnt_q - 1'b1;
                    if (squashCnt_q <= SQ_W'(1)) begin
                        state_d     = RUN;
                        squashCnt_d = '0;
                    end
                end
                default: begin
                    if (loadUse) begin
                        pcWrite    = 1'b0;
                        ifidWrite  = 1'b0;
                        idexBubble = 1'b1;
                        stallEvt   = 1'b1;
                        state_d    = LDSTALL;
                    end else begin
                        state_d    = RUN;
                    end
                end
            endcase
        end
    end

    // While reset is held, the front end is frozen and ID/EX is kept
    // empty. The gating is combinational, so an asserted reset takes
    // effect immediately, even mid-stall or mid-flush.
    assign pc_write    = rst_n & pcWrite;
    assign ifid_write  = rst_n & ifidWrite;
    assign ifid_flush  = rst_n & ifidFlush;
    assign idex_bubble = ~rst_n | idexBubble;
    assign hz_state    = state_q;

    // Saturating performance counters. They stick at all-ones, so a long
    // run never wraps back to a misleadingly small number.
    always_comb begin
        stallCnt_d = stallCnt_q;
        flushCnt_d = flushCnt_q;
        if (stallEvt && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + 1'b1;
        end
        if (squashEvt && (flushCnt_q != '1)) begin
            flushCnt_d = flushCnt_q + 1'b1;
        end
    end

    assign stall_cnt = stallCnt_q;
    assign flush_cnt = flushCnt_q;

    // FSM state and the remaining-squash counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            squashCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            squashCnt_q <= squashCnt_d;
        end
    end

    // Scoreboard shadowing the ID/EX and EX/MEM registers. A bubble
    // enters EX as an all-zero entry, so it can never create a hazard
    // later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exRd_q  <= '0;
            exWr_q  <= 1'b0;
            exLd_q  <= 1'b0;
            memRd_q <= '0;
            memWr_q <= 1'b0;
            memLd_q <= 1'b0;
        end else begin
            if (idexBubble) begin
                exRd_q <= '0;
                exWr_q <= 1'b0;
                exLd_q <= 1'b0;
            end else begin
                exRd_q <= idRd;
                exWr_q <= id_regwrite;
                exLd_q <= id_memread;
            end
            memRd_q <= exRd_q;
            memWr_q <= exWr_q;
            memLd_q <= exLd_q;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCnt_q <= '0;
            flushCnt_q <= '0;
        end else begin
            stallCnt_q <= stallCnt_d;
            flushCnt_q <= flushCnt_d;
        end
    end

endmodule

// File: tb/tb_idex_hazard_ctrl.sv
// ============================================================================
// TbIdexHazardCtrl -- testbench for idex_hazard_ctrl (module tb_idex_hazard_ctrl)
// ============================================================================
// Two instances share one stimulus stream:
//   dutA: FLUSH_CYCLES=1, CNT_W=16
//   dutB: FLUSH_CYCLES=3, CNT_W=4
// Each instance is compared every cycle against a cycle-level reference
// model. The model keeps a remaining-squash count, the last-cycle stall flag
// and the instruction sitting in EX. Directed sequences come first, followed
// by randomized traffic with occasional asynchronous resets.
// ============================================================================
module tb_idex_hazard_ctrl;

    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] LW5    = 32'h0002A283;
    localparam logic [31:0] ADD657 = 32'h00728333;
    localparam logic [31:0] LUI5   = 32'h000052B7;
    localparam logic [31:0] LW0    = 32'h0002A003;
    localparam logic [31:0] ADD607 = 32'h00700333;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] idInstr = NOP;
    logic        idRegwrite = 1'b0;
    logic        idMemread = 1'b0;
    logic        exRedirect = 1'b0;

    logic        pcWriteA, ifidWriteA, ifidFlushA, idexBubbleA;
    logic [1:0]  hzStateA;
    logic [15:0] stallCntA, flushCntA;
    logic        pcWriteB, ifidWriteB, ifidFlushB, idexBubbleB;
    logic [1:0]  hzStateB;
    logic [3:0]  stallCntB, flushCntB;

    int totalChecks = 0;
    int badChecks   = 0;
    int cycleNo     = 0;

    // Per-instance reference model state.
    int fcOf[2]   = '{1, 3};
    int maxOf[2]  = '{65535, 15};
    int squashLeft[2];
    int stallCnt[2];
    int flushCnt[2];
    int exRd[2];
    bit exWr[2];
    bit exLd[2];
    bit lastStall[2];

    always #5 clk = ~clk;

    idex_hazard_ctrl #(.RA_W(5), .FLUSH_CYCLES(1), .CNT_W(16)) dutA (
        .clk(clk), .rst_n(rst_n), .id_instr(idInstr),
        .id_regwrite(idRegwrite), .id_memread(idMemread),
        .ex_redirect(exRedirect), .pc_write(pcWriteA),
        .ifid_write(ifidWriteA), .ifid_flush(ifidFlushA),
        .idex_bubble(idexBubbleA), .hz_state(hzStateA),
        .stall_cnt(stallCntA), .flush_cnt(flushCntA)
    );

    idex_hazard_ctrl #(.RA_W(5), .FLUSH_CYCLES(3), .CNT_W(4)) dutB (
        .clk(clk), .rst_n(rst_n), .id_instr(idInstr),
        .id_regwrite(idRegwrite), .id_memread(idMemread),
        .ex_redirect(exRedirect), .pc_write(pcWriteB),
        .ifid_write(ifidWriteB), .ifid_flush(ifidFlushB),
        .idex_bubble(idexBubbleB), .hz_state(hzStateB),
        .stall_cnt(stallCntB), .flush_cnt(flushCntB)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        totalChecks++;
        if (observed != expected) begin
            badChecks++;
            $display("[TB] FAIL %s (cycle %0d): got %0d expected %0d", tag, cycleNo, observed, expected);
        end
    endtask

    function automatic bit usesRs1(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011,
                          7'b0010011, 7'b0000011, 7'b1100111};
    endfunction

    function automatic bit usesRs2(input logic [6:0] op);
        return op inside {7'b0110011, 7'b0100011, 7'b1100011};
    endfunction

    function automatic logic [31:0] mkInstr(input logic [6:0] op, input int rd, input int rs1, input int rs2);
        logic [4:0] rdB, rs1B, rs2B;
        rdB  = 5'(rd);
        rs1B = 5'(rs1);
        rs2B = 5'(rs2);
        return {7'b0, rs2B, rs1B, 3'b0, rdB, op};
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            squashLeft[k] = 0;
            stallCnt[k]   = 0;
            flushCnt[k]   = 0;
            exRd[k]       = 0;
            exWr[k]       = 0;
            exLd[k]       = 0;
            lastStall[k]  = 0;
        end
    endtask

    // Called just after a falling edge: asserts reset mid-cycle, checks the
    // held-in-reset outputs of both instances, then releases on a later
    // falling edge.
    task automatic doReset();
        rst_n      = 1'b0;
        idInstr    = NOP;
        idRegwrite = 1'b0;
        idMemread  = 1'b0;
        exRedirect = 1'b0;
        #1;
        checkOutput("rstA pc_write",    int'(pcWriteA),    0);
        checkOutput("rstA ifid_write",  int'(ifidWriteA),  0);
        checkOutput("rstA ifid_flush",  int'(ifidFlushA),  0);
        checkOutput("rstA idex_bubble", int'(idexBubbleA), 1);
        checkOutput("rstA hz_state",    int'(hzStateA),    0);
        checkOutput("rstA stall_cnt",   int'(stallCntA),   0);
        checkOutput("rstA flush_cnt",   int'(flushCntA),   0);
        checkOutput("rstB pc_write",    int'(pcWriteB),    0);
        checkOutput("rstB ifid_write",  int'(ifidWriteB),  0);
        checkOutput("rstB ifid_flush",  int'(ifidFlushB),  0);
        checkOutput("rstB idex_bubble", int'(idexBubbleB), 1);
        checkOutput("rstB hz_state",    int'(hzStateB),    0);
        checkOutput("rstB stall_cnt",   int'(stallCntB),   0);
        checkOutput("rstB flush_cnt",   int'(flushCntB),   0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        modelReset();
    endtask

    // Called just after a falling edge: drives one cycle of inputs, checks
    // both instances against the model, advances the model across the
    // coming rising edge and returns at the next falling edge.
    task automatic applyStimulus(input logic [31:0] instr, input logic rw, input logic mr, input logic redir);
        int  rs1, rs2, rd;
        bit  u1, u2, loadUse, squash, stall;
        int  expPc, expIfw, expFl, expBub, expState;
        int  obsPc, obsIfw, obsFl, obsBub, obsState, obsStall, obsFlush;
        string who;

        idInstr    = instr;
        idRegwrite = rw;
        idMemread  = mr;
        exRedirect = redir;
        #1;
        rd  = int'(instr[11:7]);
        rs1 = int'(instr[19:15]);
        rs2 = int'(instr[24:20]);
        u1  = usesRs1(instr[6:0]);
        u2  = usesRs2(instr[6:0]);

        for (int k = 0; k < 2; k++) begin
            loadUse = exLd[k] && exWr[k] && (exRd[k] != 0) &&
                      ((exRd[k] == rs1 && u1) || (exRd[k] == rs2 && u2));
            squash  = redir || (squashLeft[k] > 0);
            stall   = !squash && loadUse;

            expPc    = stall ? 0 : 1;
            expIfw   = stall ? 0 : 1;
            expFl    = squash ? 1 : 0;
            expBub   = (squash || stall) ? 1 : 0;
            expState = (squashLeft[k] > 0) ? 2 : (lastStall[k] ? 1 : 0);

            if (k == 0) begin
                who = "A";
                obsPc = int'(pcWriteA);     obsIfw = int'(ifidWriteA);
                obsFl = int'(ifidFlushA);   obsBub = int'(idexBubbleA);
                obsState = int'(hzStateA);
                obsStall = int'(stallCntA); obsFlush = int'(flushCntA);
            end else begin
                who = "B";
                obsPc = int'(pcWriteB);     obsIfw = int'(ifidWriteB);
                obsFl = int'(ifidFlushB);   obsBub = int'(idexBubbleB);
                obsState = int'(hzStateB);
                obsStall = int'(stallCntB); obsFlush = int'(flushCntB);
            end

            checkOutput({who, " pc_write"},    obsPc,    expPc);
            checkOutput({who, " ifid_write"},  obsIfw,   expIfw);
            checkOutput({who, " ifid_flush"},  obsFl,    expFl);
            checkOutput({who, " idex_bubble"}, obsBub,   expBub);
            checkOutput({who, " hz_state"},    obsState, expState);
            checkOutput({who, " stall_cnt"},   obsStall, stallCnt[k]);
            checkOutput({who, " flush_cnt"},   obsFlush, flushCnt[k]);

            // Advance the model across the next rising edge.
            if (squash && flushCnt[k] < maxOf[k]) flushCnt[k]++;
            if (stall && stallCnt[k] < maxOf[k]) stallCnt[k]++;
            if (redir) squashLeft[k] = fcOf[k] - 1;
            else if (squashLeft[k] > 0) squashLeft[k]--;
            lastStall[k] = stall;
            if (squash || stall) begin
                exRd[k] = 0; exWr[k] = 0; exLd[k] = 0;
            end else begin
                exRd[k] = rd; exWr[k] = rw; exLd[k] = mr;
            end
        end
        cycleNo++;
        @(negedge clk);
    endtask

    logic [6:0] opList[10] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011,
                               7'b0000011, 7'b1100111, 7'b0110111, 7'b0010111,
                               7'b1101111, 7'b1111111};

    initial begin
        logic [6:0] op;
        logic       rw, mr, rd;
        modelReset();
        @(negedge clk);

        // Initial reset.
        doReset();

        // Load-use: a single stall cycle, then the dependent add proceeds.
        applyStimulus(LW5, 1'b1, 1'b1, 1'b0);
        applyStimulus(ADD657, 1'b1, 1'b0, 1'b0);
        checkOutput("T2 stall_cnt A", int'(stallCntA), 1);
        checkOutput("T2 hz_state A", int'(hzStateA), 1);
        applyStimulus(ADD657, 1'b1, 1'b0, 1'b0);

        // No false stalls: load to x0, lui that reads nothing, MEM-stage hit.
        applyStimulus(LW0, 1'b1, 1'b1, 1'b0);
        applyStimulus(ADD607, 1'b1, 1'b0, 1'b0);
        applyStimulus(LW5, 1'b1, 1'b1, 1'b0);
        applyStimulus(LUI5, 1'b1, 1'b0, 1'b0);
        applyStimulus(LW5, 1'b1, 1'b1, 1'b0);
        applyStimulus(NOP, 1'b1, 1'b0, 1'b0);
        applyStimulus(ADD657, 1'b1, 1'b0, 1'b0);
        checkOutput("T3 stall_cnt A", int'(stallCntA), 1);

        // Redirect in the same cycle as a load-use: the squash wins.
        applyStimulus(LW5, 1'b1, 1'b1, 1'b0);
        applyStimulus(ADD657, 1'b1, 1'b0, 1'b1);
        checkOutput("T4 stall_cnt A", int'(stallCntA), 1);
        checkOutput("T4 flush_cnt A", int'(flushCntA), 1);
        checkOutput("T4 mid-flush state B", int'(hzStateB), 2);

        // Reset while dutB is mid-flush, then RUN outputs after release.
        doReset();
        applyStimulus(NOP, 1'b1, 1'b0, 1'b0);

        // Three-cycle squash, then a redirect landing in squash cycle 2.
        applyStimulus(NOP, 1'b1, 1'b0, 1'b1);
        repeat (3) applyStimulus(NOP, 1'b1, 1'b0, 1'b0);
        checkOutput("T5 flush_cnt B", int'(flushCntB), 3);
        applyStimulus(NOP, 1'b1, 1'b0, 1'b1);
        applyStimulus(NOP, 1'b1, 1'b0, 1'b1);
        repeat (4) applyStimulus(NOP, 1'b1, 1'b0, 1'b0);
        checkOutput("T5 extended flush_cnt B", int'(flushCntB), 7);

        // Counter saturation on the 4-bit instance.
        doReset();
        repeat (20) begin
            applyStimulus(LW5, 1'b1, 1'b1, 1'b0);
            applyStimulus(ADD657, 1'b1, 1'b0, 1'b0);
            applyStimulus(ADD657, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("T6 stall_cnt B", int'(stallCntB), 15);
        checkOutput("T6 stall_cnt A", int'(stallCntA), 20);

        // Randomized traffic on a small register set so hazards are common.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                doReset();
            end else begin
                op = opList[$urandom_range(0, 9)];
                rw = 1'($urandom_range(0, 3) != 0);
                mr = (op == 7'b0000011) ? 1'($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 7) == 0);
                rd = 1'($urandom_range(0, 9) == 0);
                applyStimulus(mkInstr(op, rd ? 0 : int'($urandom_range(1, 3)),
                                      int'($urandom_range(0, 3)), int'($urandom_range(0, 3))),
                              rw, mr, 1'($urandom_range(0, 9) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
